// File: rtl/shifter_pkg.sv
// Shared definitions for the registered barrel shifter: default data width
// and the operation encodings carried on the Mode input.
package shifter_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

endpackage

// File: rtl/shifter_stage.sv
// One barrel stage: shifts or rotates by a fixed distance DIST when en is set,
// otherwise passes data through untouched.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shifted;

    // An arithmetic shift keeps the MSB equal to the original sign bit, so
    // each stage can replicate its own MSB and the cascade stays correct.
    always_comb begin
        shifted = data_in;
        case (mode)
            MODE_SLL: shifted = data_in << DIST;
            MODE_SRA: shifted = $signed(data_in) >>> DIST;
            MODE_ROR: shifted = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
            MODE_SRL: shifted = data_in >> DIST;
            default:  shifted = data_in;
        endcase
    end

    assign data_out = en ? shifted : data_in;

endmodule

// File: rtl/shifter.sv
// Registered barrel shifter: log2(WIDTH) shift stages selected by the bits of
// Shift_Val, followed by a single output register (one-cycle latency).
module shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         Shift_In,
    input  logic [$clog2(WIDTH)-1:0] Shift_Val,
    input  logic [1:0]               Mode,
    output logic [WIDTH-1:0]         Shift_Out
);

    localparam int STAGES = $clog2(WIDTH);

    logic [WIDTH-1:0] stage_data [STAGES+1];

    assign stage_data[0] = Shift_In;

    // Stage k moves the data by 2^k positions when Shift_Val[k] is set.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_in  (stage_data[k]),
            .en       (Shift_Val[k]),
            .mode     (Mode),
            .data_out (stage_data[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Shift_Out <= '0;
        end else begin
            Shift_Out <= stage_data[STAGES];
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: a word-level reference model compared every
// cycle, directed vectors with literal results, reset behaviour and random traffic.
module tb_shifter;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  Shift_In;
    logic [SW-1:0] Shift_Val;
    logic [1:0]    Mode;
    logic [W-1:0]  Shift_Out;

    int checks   = 0;
    int failures = 0;
    bit pipe_on  = 1'b0;

    shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Shift_In  (Shift_In),
        .Shift_Val (Shift_Val),
        .Mode      (Mode),
        .Shift_Out (Shift_Out)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model at word level: rotation through a doubled word,
    // shifts via the language operators.
    function automatic logic [W-1:0] ref_shift(logic [W-1:0] a, int n, logic [1:0] m);
        logic [2*W-1:0] wide;
        logic [W-1:0]   r;
        case (m)
            2'b00:   r = a << n;
            2'b01:   r = $signed(a) >>> n;
            2'b10: begin
                wide = {a, a} >> n;
                r = wide[W-1:0];
            end
            default: r = a >> n;
        endcase
        return r;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected result is captured at each edge and checked just after it.
    logic [W-1:0] exp_q[$];

    always @(posedge clk) begin
        exp_q.push_back(rst_n ? ref_shift(Shift_In, int'(Shift_Val), Mode) : '0);
        #1;
        if (pipe_on && exp_q.size() > 0) begin
            check("pipe", Shift_Out, exp_q.pop_front());
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    task automatic drive(logic [W-1:0] a, logic [SW-1:0] n, logic [1:0] m);
        @(negedge clk);
        Shift_In  = a;
        Shift_Val = n;
        Mode      = m;
    endtask

    // Directed vector: literal expectation checks both the model and the DUT.
    task automatic apply(string name, logic [W-1:0] a, logic [SW-1:0] n,
                         logic [1:0] m, logic [W-1:0] exp);
        drive(a, n, m);
        check({name, "_model"}, ref_shift(a, int'(n), m), exp);
        @(posedge clk);
        #1;
        check(name, Shift_Out, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        Shift_In  = '0;
        Shift_Val = '0;
        Mode      = 2'b00;
        #2;
        check("reset_out", Shift_Out, 16'h0000);

        Shift_In  = 16'hBEEF;
        Shift_Val = 4'd3;
        @(posedge clk);
        #1;
        check("reset_hold", Shift_Out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_change", Shift_Out, 16'h0000);
        pipe_on = 1'b1;

        apply("sll_1",      16'h8001, 4'd1,  2'b00, 16'h0002);
        apply("sll_15",     16'h8001, 4'd15, 2'b00, 16'h8000);
        apply("sll_15_ff",  16'hFFFF, 4'd15, 2'b00, 16'h8000);
        apply("sra_15",     16'h8000, 4'd15, 2'b01, 16'hFFFF);
        apply("sra_4",      16'h7FF0, 4'd4,  2'b01, 16'h07FF);
        apply("sra_15_pos", 16'h4000, 4'd15, 2'b01, 16'h0000);
        apply("sra_3_neg",  16'hF0F0, 4'd3,  2'b01, 16'hFE1E);
        apply("ror_4",      16'h1234, 4'd4,  2'b10, 16'h4123);
        apply("ror_1",      16'h0001, 4'd1,  2'b10, 16'h8000);
        apply("ror_15",     16'h8001, 4'd15, 2'b10, 16'h0003);
        apply("ror_8",      16'hABCD, 4'd8,  2'b10, 16'hCDAB);
        apply("srl_15",     16'h8000, 4'd15, 2'b11, 16'h0001);
        apply("srl_15_ff",  16'hFFFF, 4'd15, 2'b11, 16'h0001);
        apply("srl_5",      16'hF000, 4'd5,  2'b11, 16'h0780);
        apply("zero_sll",   16'hA5C3, 4'd0,  2'b00, 16'hA5C3);
        apply("zero_sra",   16'hA5C3, 4'd0,  2'b01, 16'hA5C3);
        apply("zero_ror",   16'hA5C3, 4'd0,  2'b10, 16'hA5C3);
        apply("zero_srl",   16'hA5C3, 4'd0,  2'b11, 16'hA5C3);

        // Mid-stream reset between edges, with new inputs present while in reset.
        apply("pre_reset",  16'hFFFF, 4'd7,  2'b01, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", Shift_Out, 16'h0000);
        Shift_In  = 16'h1234;
        Shift_Val = 4'd4;
        Mode      = 2'b10;
        #3;
        rst_n = 1'b1;
        #1;
        check("post_release_hold", Shift_Out, 16'h0000);
        @(posedge clk);
        #1;
        check("first_after_reset", Shift_Out, 16'h4123);

        // Random traffic, one new operation per cycle; the scoreboard checks each.
        for (int i = 0; i < 1000; i++) begin
            drive(W'($urandom_range(0, 16'hFFFF)), SW'($urandom_range(0, W - 1)),
                  2'($urandom_range(0, 3)));
        end
        @(posedge clk);
        #2;
        pipe_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
